// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end sharing one ALU; grant -> DECODE -> EXECUTE, results 2 cycles after grant.
// No output backpressure; stall freezes both stages and blocks grants, an unpresented result re-pulses after release.
module alu_rr_scheduler #(
  parameter int DW      = 4,
  parameter int FCODE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [FCODE_W-1:0] fcode0,
  input  logic [DW-1:0]      a0,
  input  logic [DW-1:0]      b0,
  input  logic               req1,
  input  logic [FCODE_W-1:0] fcode1,
  input  logic [DW-1:0]      a1,
  input  logic [DW-1:0]      b1,
  input  logic               stall,
  output logic               gnt0,
  output logic               gnt1,
  output logic               res_valid,
  output logic               res_id,
  output logic [2:0]         res_cntrl,
  output logic [DW-1:0]      res_out,
  output logic               res_parity,
  output logic               res_err
);

  typedef struct packed {
    logic          id;
    logic [2:0]    cntrl;
    logic          err;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } s1_t;

  typedef struct packed {
    logic          id;
    logic [2:0]    cntrl;
    logic          err;
    logic [DW-1:0] out;
  } s2_t;

  logic               rr_ptr;
  logic               grant_ok;
  logic [FCODE_W-1:0] sel_fcode;
  logic [2:0]         enc_cntrl;
  s1_t                s1_nxt;
  s1_t                s1;
  logic               s1_valid;
  s2_t                s2;
  logic               s2_valid;
  logic [DW-1:0]      alu_out;

  // Requests are never granted while stalled or in reset; ties go to rr_ptr.
  assign grant_ok = ~stall & ~reset;
  assign gnt0     = grant_ok & req0 & (~req1 | ~rr_ptr);
  assign gnt1     = grant_ok & req1 & (~req0 |  rr_ptr);

  always_comb begin
    sel_fcode = gnt1 ? fcode1 : fcode0;
    enc_cntrl = '0;
    for (int i = 0; i < FCODE_W; i++) begin
      if (sel_fcode[i]) enc_cntrl = 3'(i);
    end
    s1_nxt.id    = gnt1;
    s1_nxt.cntrl = enc_cntrl;
    s1_nxt.err   = (sel_fcode == '0);
    s1_nxt.a     = gnt1 ? a1 : a0;
    s1_nxt.b     = gnt1 ? b1 : b0;
  end

  always_comb begin
    alu_out = '0;
    case (s1.cntrl)
      3'd0: alu_out = s1.a + s1.b;
      3'd1: alu_out = s1.a - s1.b;
      3'd2: alu_out = s1.a ^ s1.b;
      3'd3: alu_out = s1.a | s1.b;
      3'd4: alu_out = s1.a & s1.b;
      3'd5: alu_out = ~(s1.a | s1.b);
      3'd6: alu_out = ~(s1.a & s1.b);
      3'd7: alu_out = ~(s1.a ^ s1.b);
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      s2       <= '0;
    end else begin
      if (gnt0)      rr_ptr <= 1'b1;
      else if (gnt1) rr_ptr <= 1'b0;
      // Every unstalled edge advances both stages, so a shown result is consumed exactly once.
      if (!stall) begin
        s1_valid <= gnt0 | gnt1;
        if (gnt0 | gnt1) s1 <= s1_nxt;
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2.id    <= s1.id;
          s2.cntrl <= s1.cntrl;
          s2.err   <= s1.err;
          s2.out   <= s1.err ? '0 : alu_out;
        end
      end
    end
  end

  assign res_valid  = s2_valid & ~stall & ~reset;
  assign res_id     = s2.id;
  assign res_cntrl  = s2.cntrl;
  assign res_out    = s2.out;
  assign res_parity = ~^s2.out;
  assign res_err    = s2.err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler; a scoreboard queues expected results at each grant.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, stall;
  logic [7:0] fcode0, fcode1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1;
  logic       res_valid, res_id, res_parity, res_err;
  logic [2:0] res_cntrl;
  logic [3:0] res_out;

  typedef struct packed {
    logic       id;
    logic [2:0] cntrl;
    logic       err;
    logic [3:0] out;
    logic       par;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;
  int   n_res = 0;
  int   cyc = 0;
  int   last_res_cyc = 0;

  alu_rr_scheduler #(.DW(4), .FCODE_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .fcode0(fcode0), .a0(a0), .b0(b0),
    .req1(req1), .fcode1(fcode1), .a1(a1), .b1(b1),
    .stall(stall), .gnt0(gnt0), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_cntrl(res_cntrl),
    .res_out(res_out), .res_parity(res_parity), .res_err(res_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: highest set fcode bit picks the op, results wrap at 4 bits.
  function automatic exp_t model(input logic id, input logic [7:0] f,
                                 input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   c;
    int   r;
    c = -1;
    for (int i = 7; i >= 0; i--) if (f[i] && c < 0) c = i;
    case (c)
      0: r = int'(a) + int'(b);
      1: r = int'(a) - int'(b);
      2: r = int'(a ^ b);
      3: r = int'(a | b);
      4: r = int'(a & b);
      5: r = int'(~(a | b));
      6: r = int'(~(a & b));
      7: r = int'(~(a ^ b));
      default: r = 0;
    endcase
    e.id  = id;
    e.err = (c < 0);
    e.cntrl = 3'd0;
    if (c >= 0) e.cntrl = 3'(c);
    e.out = 4'(r & 15);
    e.par = ($countones(e.out) % 2 == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("res_unexpected", {31'd0, res_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_id",     {31'd0, res_id},     {31'd0, e.id});
        chk("res_cntrl",  {29'd0, res_cntrl},  {29'd0, e.cntrl});
        chk("res_err",    {31'd0, res_err},    {31'd0, e.err});
        chk("res_out",    {28'd0, res_out},    {28'd0, e.out});
        chk("res_parity", {31'd0, res_parity}, {31'd0, e.par});
      end
      last = {res_id, res_cntrl, res_err, res_out, res_parity};
      last_res_cyc = cyc;
      n_res++;
    end
    if (gnt0) sb.push_back(model(1'b0, fcode0, a0, b0));
    if (gnt1) sb.push_back(model(1'b1, fcode1, a1, b1));
  end

  task automatic issue(input logic id, input logic [7:0] f, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] ec, input logic [3:0] eo,
                       input logic ep, input logic ee);
    bit got;
    int gcyc;
    int start;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; fcode1 = f; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; fcode0 = f; a0 = a; b0 = b; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (id ? gnt1 : gnt0) got = 1'b1;
    end
    chk("grant_seen", {31'd0, got}, 32'd1);
    gcyc  = cyc;
    start = n_res;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      if (n_res > start) got = 1'b1;
    end
    chk("result_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("latency",    last_res_cyc - gcyc, 32'd2);
      chk("vec_id",     {31'd0, last.id},    {31'd0, id});
      chk("vec_cntrl",  {29'd0, last.cntrl}, {29'd0, ec});
      chk("vec_out",    {28'd0, last.out},   {28'd0, eo});
      chk("vec_parity", {31'd0, last.par},   {31'd0, ep});
      chk("vec_err",    {31'd0, last.err},   {31'd0, ee});
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic e0, e1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
    fcode0 = '0; fcode1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid",  {31'd0, res_valid},  32'd0);
    chk("rst_id",     {31'd0, res_id},     32'd0);
    chk("rst_cntrl",  {29'd0, res_cntrl},  32'd0);
    chk("rst_out",    {28'd0, res_out},    32'd0);
    chk("rst_parity", {31'd0, res_parity}, 32'd1);
    chk("rst_err",    {31'd0, res_err},    32'd0);
    chk("rst_gnt",    {30'd0, gnt1, gnt0}, 32'd0);

    // single-requester vectors
    issue(1'b0, 8'b0000_0001, 4'b0001, 4'b1010, 3'd0, 4'b1011, 1'b0, 1'b0);
    issue(1'b1, 8'b0001_0000, 4'b0010, 4'b1010, 3'd4, 4'b0010, 1'b0, 1'b0);
    issue(1'b1, 8'b0100_0000, 4'b0100, 4'b1010, 3'd6, 4'b1111, 1'b1, 1'b0);
    issue(1'b0, 8'b0001_0001, 4'b0001, 4'b1010, 3'd4, 4'b0000, 1'b1, 1'b0);
    issue(1'b0, 8'b0000_0000, 4'b0111, 4'b0101, 3'd0, 4'b0000, 1'b1, 1'b1);
    issue(1'b0, 8'b0000_0010, 4'b0001, 4'b1010, 3'd1, 4'b0111, 1'b0, 1'b0);
    issue(1'b1, 8'b1000_0000, 4'b0101, 4'b0011, 3'd7, 4'b1001, 1'b1, 1'b0);
    issue(1'b1, 8'b0010_0100, 4'b1100, 4'b0110, 3'd5, 4'b0001, 1'b0, 1'b0);

    // both held after reset: alternating grants, back-to-back results
    reset_dut();
    req0 = 1'b1; fcode0 = 8'h01; a0 = 4'd3; b0 = 4'd4;
    req1 = 1'b1; fcode1 = 8'h04; a1 = 4'd5; b1 = 4'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      e0 = (i < 4) && (i % 2 == 0);
      e1 = (i < 4) && (i % 2 == 1);
      chk("rr_gnt0", {31'd0, gnt0}, {31'd0, e0});
      chk("rr_gnt1", {31'd0, gnt1}, {31'd0, e1});
      if (i >= 2) chk("rr_b2b_valid", {31'd0, res_valid}, 32'd1);
      if (i == 3) begin
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(negedge clk); #1;
    chk("rr_drained", {31'd0, res_valid}, 32'd0);

    // stall with two ops in flight
    @(posedge clk); #1;
    req0 = 1'b1; fcode0 = 8'h08; a0 = 4'b1001; b0 = 4'b0100;
    req1 = 1'b1; fcode1 = 8'h02; a1 = 4'b0011; b1 = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("stl_pre_gnt", {31'd0, gnt0 | gnt1}, 32'd1);
    end
    @(posedge clk); #1;
    stall = 1'b1; req1 = 1'b0;
    req0 = 1'b1; fcode0 = 8'h20; a0 = 4'b1010; b0 = 4'b0001;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stl_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
      chk("stl_valid", {31'd0, res_valid},  32'd0);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk); #1;
    chk("stl_rel_valid0", {31'd0, res_valid}, 32'd1);
    chk("stl_rel_gnt0",   {31'd0, gnt0},      32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk); #1;
    chk("stl_rel_valid1", {31'd0, res_valid}, 32'd1);
    @(negedge clk); #1;
    chk("stl_rel_valid2", {31'd0, res_valid}, 32'd1);
    @(negedge clk); #1;
    chk("stl_done", {31'd0, res_valid}, 32'd0);

    // reset with two ops in flight, requests held through reset
    @(posedge clk); #1;
    req0 = 1'b1; fcode0 = 8'h01; a0 = 4'd1; b0 = 4'd1;
    req1 = 1'b1; fcode1 = 8'h01; a1 = 4'd2; b1 = 4'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("mrst_pre_gnt", {31'd0, gnt0 | gnt1}, 32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    repeat (2) begin
      @(negedge clk); #1;
      chk("mrst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
      chk("mrst_valid", {31'd0, res_valid},  32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk); #1;
    chk("mrst_gnt0_first", {31'd0, gnt0},      32'd1);
    chk("mrst_gnt1_first", {31'd0, gnt1},      32'd0);
    chk("mrst_no_old_res", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); #1;
    chk("mrst_no_old_res2", {31'd0, res_valid}, 32'd0);
    @(negedge clk); #1;
    chk("mrst_new_res", {31'd0, res_valid}, 32'd1);
    @(negedge clk); #1;
    chk("mrst_idle", {31'd0, res_valid}, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
